carry_resolve_packer: RTL
=========================

// Module: carry_resolve_packer
// PURPOSE
// - Downstream of the 3-lane parallel-bool arithmetic encoder. Consumes its three pre-bitstream lanes (two 16-bit precarry words + 2-bit flag per lane) and resolves carries.
// - Holds the last emitted byte plus a run of pending 0xFF bytes until a later carry settles them. Emits final AV1 bitstream bytes over a ready/valid port.
// - Drives in_ready back to the encoder pipeline control unit, which freezes all pipeline registers while in_ready=0.
// PARAMETERS
// - WORD_WIDTH 16 : pre-bitstream word width; bits [7:0] = byte, bit [8] = carry into held byte, bits [WORD_WIDTH-1:9] must be 0.
// - RUN_WIDTH  16 : width of the pending-0xFF run counter.
// PORTS
// - general_clk      in  1   : clock.
// - reset            in  1   : asynchronous, active-low reset.
// - in_valid         in  1   : lane group valid (one encoder output cycle).
// - in_ready         out 1   : group accepted on in_valid&in_ready.
// - in_bit_{1,2,3}_1 in  16  : first word of lane 1/2/3.
// - in_bit_{1,2,3}_2 in  16  : second word of lane 1/2/3.
// - in_flag_{1,2,3}  in  2   : bit0 = word _1 valid, bit1 = word _2 valid (word _2 without _1 is legal and means _2 only).
// - flush            in  1   : end-of-frame pulse; sampled only when in_ready=1; higher priority than in_valid.
// - out_byte         out 8   : resolved bitstream byte.
// - out_valid        out 1   : out_byte valid; out_byte held stable while out_valid&!out_ready.
// - out_ready        in  1   : downstream accepts byte.
// - out_last         out 1   : high with the final byte of a flush.
// - error            out 1   : sticky; carry with no held byte, held-byte overflow, run counter saturation, or nonzero bits [15:9].
// BEHAVIOUR
// - Reset: in_ready=0 for the first cycle after deassertion, then 1. out_valid=0, out_byte=0, out_last=0, error=0. held empty, run=0, FSM=IDLE.
// - Group capture: on accept, latch all six words and flags. Process valid words one per cycle in order 1_1,1_2,2_1,2_2,3_1,3_2.
//   - in_ready=0 while latched words remain or an emission is active.
//   - in_ready returns to 1 in the cycle the last word is processed, if that word triggers no emission.
//   - An all-zero-flag group is accepted and costs 1 cycle.
// - Per word (byte b, carry c):
//   - No byte held: held<=b; c=1 sets error and is otherwise ignored.
//   - Held and c=0 and b==0xFF: run<=run+1 (saturates at 2^RUN_WIDTH-1 and sets error).
//   - Otherwise: emit (held+c)[7:0]; then emit run bytes of value (c ? 0x00 : 0xFF); then held<=b, run<=0.
//   - held==0xFF with c=1: emit 0x00 and set error.
// - FSM states and transitions:
//   - IDLE: waiting for a group or flush.
//   - PROC: serializing words of the latched group.
//   - EMIT_HELD: presents held+c; moves on at handshake.
//   - EMIT_RUN: decrements run per handshake; when run reaches 0, goes to PROC if words remain, else IDLE.
//   - FLUSH_HELD, FLUSH_RUN: emit held, then run x 0xFF; out_last on the last byte; then IDLE with held cleared.
// - Flush with nothing held: no bytes are emitted and out_last is not asserted; returns to IDLE the next cycle.
// - Latency: the first byte appears 2 cycles after accept of the triggering group (PROC, then EMIT_HELD registered). Throughput is 1 byte/cycle when out_ready=1.
// - Back-pressure: out_ready=0 stalls the FSM in place. No input is accepted and no state changes except error.
// - Reset mid-operation: all state is discarded immediately (async). Partial bytes are never emitted afterwards.
// STRUCTURE
// - Shared package entries:
//   - FSM state enum (IDLE, PROC, EMIT_HELD, EMIT_RUN, FLUSH_HELD, FLUSH_RUN).
//   - BYTE_FF=8'hFF constant.
//   - Word field constants (BYTE_LSB=0, BYTE_MSB=7, CARRY_BIT=8).
// - One natural sub-module: lane_word_serializer. It holds the latched 6-word group and valid mask and yields the next valid word plus a last flag per advance.
// TESTING
// - Reset, then lane1 flag=01 word=0x0012, flag=01 word=0x0034 in the next group -> out byte 0x12 only; 0x34 stays held.
// - Hold 0x12, then words 0x00FF, 0x00FF, 0x0100 (carry, b=0x00) -> bytes 0x13,0x00,0x00; held=0x00, run=0.
// - Hold 0x12, then 0x00FF, 0x00FF, 0x0056 -> bytes 0x12,0xFF,0xFF; held=0x56.
// - One group with all six words valid (0x01..0x06) and out_ready toggling every cycle -> bytes 0x01..0x05 in order, stable under stall; in_ready=0 until done.
// - Held 0x7A, run=2, then flush -> 0x7A,0xFF,0xFF with out_last on the 3rd byte; then idle with nothing held.
// - Carry 0x0100 as the first word after reset -> error=1 stays set; reset asserted mid EMIT_RUN -> out_valid=0 immediately, no further bytes.

Source files
------------

// File: rtl/carry_resolve_packer_pkg.sv
// Shared types and constants for the carry-resolving bitstream packer.
package carry_resolve_packer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PROC,
    EMIT_HELD,
    EMIT_RUN,
    FLUSH_HELD,
    FLUSH_RUN
  } state_e;

  localparam logic [7:0] BYTE_FF   = 8'hFF;
  localparam int         BYTE_LSB  = 0;
  localparam int         BYTE_MSB  = 7;
  localparam int         CARRY_BIT = 8;

  // A carry turns the pending 0xFF run into 0x00 bytes.
  function automatic logic [7:0] fill_byte(input logic carry);
    return carry ? 8'h00 : BYTE_FF;
  endfunction

endpackage

// File: rtl/carry_resolve_packer_if.sv
// Encoder-side lane group input and byte-stream output of the packer.
interface carry_resolve_packer_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_bit_1_1, in_bit_1_2;
  logic [WORD_WIDTH-1:0] in_bit_2_1, in_bit_2_2;
  logic [WORD_WIDTH-1:0] in_bit_3_1, in_bit_3_2;
  logic [1:0]            in_flag_1, in_flag_2, in_flag_3;
  logic                  flush;
  logic [7:0]            out_byte;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  error;

  modport master (
    output in_valid, in_bit_1_1, in_bit_1_2, in_bit_2_1, in_bit_2_2,
           in_bit_3_1, in_bit_3_2, in_flag_1, in_flag_2, in_flag_3,
           flush, out_ready,
    input  in_ready, out_byte, out_valid, out_last, error
  );

  modport slave (
    input  in_valid, in_bit_1_1, in_bit_1_2, in_bit_2_1, in_bit_2_2,
           in_bit_3_1, in_bit_3_2, in_flag_1, in_flag_2, in_flag_3,
           flush, out_ready,
    output in_ready, out_byte, out_valid, out_last, error
  );
endinterface

// File: rtl/carry_resolve_packer_lane_word_serializer.sv
// Holds one latched 6-word lane group and hands out its valid words lowest index first.
module lane_word_serializer #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] words_i [6],
  input  logic [5:0]            mask_i,
  input  logic                  advance_i,
  output logic                  has_word_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  last_o
);
  logic [WORD_WIDTH-1:0] words_q [6];
  logic [WORD_WIDTH-1:0] gated   [6];
  logic [5:0]            mask_q;
  logic [5:0]            pick;
  logic [5:0]            rest;

  // Isolate the lowest pending word; the rest is what remains after an advance.
  assign pick = mask_q & (~mask_q + 6'd1);
  assign rest = mask_q & ~pick;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_gate
      assign gated[gi] = words_q[gi] & {WORD_WIDTH{pick[gi]}};
    end
  endgenerate

  always_comb begin
    word_o = '0;
    for (int i = 0; i < 6; i++) begin
      word_o = word_o | gated[i];
    end
  end

  assign has_word_o = |mask_q;
  assign last_o     = (rest == 6'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
    end else if (load_i) begin
      mask_q <= mask_i;
    end else if (advance_i) begin
      mask_q <= rest;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      words_q <= words_i;
    end
  end
endmodule

// File: rtl/carry_resolve_packer.sv
// Resolves encoder carries into final bitstream bytes, holding the last byte and a run of 0xFF.
module carry_resolve_packer
  import carry_resolve_packer_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int RUN_WIDTH  = 16
) (
  input  logic                 general_clk_i,
  input  logic                 reset_ni,
  carry_resolve_packer_if.slave bus
);
  state_e                 state_q, state_d;
  logic [7:0]             held_q, held_d;
  logic                   held_vld_q, held_vld_d;
  logic [RUN_WIDTH-1:0]   run_q, run_d;
  logic [7:0]             emit_q, emit_d;
  logic [7:0]             fill_q, fill_d;
  logic                   error_q, error_d;
  logic                   rdy_q;

  logic [WORD_WIDTH-1:0]  words [6];
  logic [WORD_WIDTH-1:0]  ser_word;
  logic                   ser_has, ser_last, load, advance;
  logic                   in_ready_c, out_valid_c, out_last_c, out_hs, emit_now;
  logic [7:0]             out_byte_c, w_byte;
  logic                   w_carry, hi_bad;

  assign words[0] = bus.in_bit_1_1;
  assign words[1] = bus.in_bit_1_2;
  assign words[2] = bus.in_bit_2_1;
  assign words[3] = bus.in_bit_2_2;
  assign words[4] = bus.in_bit_3_1;
  assign words[5] = bus.in_bit_3_2;

  lane_word_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
    .clk_i      (general_clk_i),
    .rst_ni     (reset_ni),
    .load_i     (load),
    .words_i    (words),
    .mask_i     ({bus.in_flag_3, bus.in_flag_2, bus.in_flag_1}),
    .advance_i  (advance),
    .has_word_o (ser_has),
    .word_o     (ser_word),
    .last_o     (ser_last)
  );

  assign w_byte  = ser_word[BYTE_MSB:BYTE_LSB];
  assign w_carry = ser_word[CARRY_BIT];
  assign hi_bad  = |ser_word[WORD_WIDTH-1:CARRY_BIT+1];
  assign out_hs  = out_valid_c & bus.out_ready;

  // run_q doubles as the countdown of pending bytes while they are being emitted.
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    run_d      = run_q;
    emit_d     = emit_q;
    fill_d     = fill_q;
    error_d    = error_q;
    load       = 1'b0;
    advance    = 1'b0;
    in_ready_c = 1'b0;
    emit_now   = 1'b0;
    unique case (state_q)
      IDLE: in_ready_c = rdy_q;
      PROC: begin
        if (!ser_has) begin
          in_ready_c = 1'b1;
          state_d    = IDLE;
        end else begin
          advance = 1'b1;
          if (hi_bad) error_d = 1'b1;
          if (!held_vld_q) begin
            held_d     = w_byte;
            held_vld_d = 1'b1;
            if (w_carry) error_d = 1'b1;
          end else if (!w_carry && w_byte == BYTE_FF) begin
            if (&run_q) error_d = 1'b1;
            else        run_d   = run_q + RUN_WIDTH'(1);
          end else begin
            emit_now = 1'b1;
            emit_d   = held_q + {7'd0, w_carry};
            fill_d   = fill_byte(w_carry);
            held_d   = w_byte;
            state_d  = EMIT_HELD;
            if (w_carry && held_q == BYTE_FF) error_d = 1'b1;
          end
          if (!emit_now && ser_last) begin
            in_ready_c = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      EMIT_HELD: begin
        if (out_hs) state_d = (run_q != '0) ? EMIT_RUN : (ser_has ? PROC : IDLE);
      end
      EMIT_RUN: begin
        if (out_hs) begin
          run_d = run_q - RUN_WIDTH'(1);
          if (run_q == RUN_WIDTH'(1)) state_d = ser_has ? PROC : IDLE;
        end
      end
      FLUSH_HELD: begin
        if (!held_vld_q) begin
          state_d = IDLE;
        end else if (out_hs) begin
          if (run_q == '0) begin
            state_d    = IDLE;
            held_vld_d = 1'b0;
          end else begin
            state_d = FLUSH_RUN;
          end
        end
      end
      FLUSH_RUN: begin
        if (out_hs) begin
          run_d = run_q - RUN_WIDTH'(1);
          if (run_q == RUN_WIDTH'(1)) begin
            state_d    = IDLE;
            held_vld_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (in_ready_c) begin
      if (bus.flush) begin
        state_d = FLUSH_HELD;
      end else if (bus.in_valid) begin
        load    = 1'b1;
        state_d = PROC;
      end
    end
  end

  always_comb begin
    out_valid_c = 1'b0;
    out_byte_c  = 8'h00;
    out_last_c  = 1'b0;
    unique case (state_q)
      EMIT_HELD: begin
        out_valid_c = 1'b1;
        out_byte_c  = emit_q;
      end
      EMIT_RUN: begin
        out_valid_c = 1'b1;
        out_byte_c  = fill_q;
      end
      FLUSH_HELD: begin
        out_valid_c = held_vld_q;
        out_byte_c  = held_vld_q ? held_q : 8'h00;
        out_last_c  = held_vld_q && (run_q == '0);
      end
      FLUSH_RUN: begin
        out_valid_c = 1'b1;
        out_byte_c  = BYTE_FF;
        out_last_c  = (run_q == RUN_WIDTH'(1));
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_byte  = out_byte_c;
  assign bus.out_last  = out_last_c;
  assign bus.error     = error_q;

  always_ff @(posedge general_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      held_q     <= 8'h00;
      held_vld_q <= 1'b0;
      run_q      <= '0;
      emit_q     <= 8'h00;
      fill_q     <= BYTE_FF;
      error_q    <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      run_q      <= run_d;
      emit_q     <= emit_d;
      fill_q     <= fill_d;
      error_q    <= error_d;
      rdy_q      <= 1'b1;
    end
  end
endmodule
